// File: rtl/frl_tx_lane_framer.sv
// Fast Radio Link TX lane framer: training bursts, framed packets
// (header, length, payload, checksum) and idle fill, one word per clk.
module frl_tx_lane_framer #(
    parameter int unsigned TRAIN_LEN  = 128,
    parameter logic [7:0]  TRAIN_WORD = 8'h5C,
    parameter logic [7:0]  HDR_WORD   = 8'hF5,
    parameter logic [7:0]  IDLE_WORD  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       train_req,
    input  logic       frame_start,
    input  logic [7:0] frame_len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] lane_data,
    output logic       lane_ctl,
    output logic       busy,
    output logic       train_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRAIN = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_LEN   = 3'd3;
    localparam logic [2:0] S_PAY   = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;

    localparam logic [7:0] TRAIN_LOAD = 8'(TRAIN_LEN - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] train_cnt_q, train_cnt_d;
    logic [7:0] len_q, len_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] lane_data_q, lane_data_d;
    logic       lane_ctl_q, lane_ctl_d;
    logic       busy_q, busy_d;
    logic       train_last_q, train_last_d;
    logic       train_done_q, train_done_d;

    assign tx_ready   = (state_q == S_PAY);
    assign lane_data  = lane_data_q;
    assign lane_ctl   = lane_ctl_q;
    assign busy       = busy_q;
    assign train_done = train_done_q;

    always_comb begin
        state_d      = state_q;
        train_cnt_d  = train_cnt_q;
        len_d        = len_q;
        rem_d        = rem_q;
        sum_d        = sum_q;
        lane_data_d  = IDLE_WORD;
        lane_ctl_d   = 1'b1;
        train_last_d = 1'b0;
        // busy tracks the word being put on the lane, hence state_q
        busy_d       = (state_q != S_IDLE);
        // delayed one extra cycle to line up with the first idle word
        train_done_d = train_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (train_req) begin
                    state_d     = S_TRAIN;
                    train_cnt_d = TRAIN_LOAD;
                end else if (frame_start) begin
                    state_d = S_HDR;
                    len_d   = frame_len;
                end
            end
            S_TRAIN: begin
                lane_data_d = TRAIN_WORD;
                if (train_cnt_q == 8'd0) begin
                    state_d      = S_IDLE;
                    train_last_d = 1'b1;
                end else begin
                    train_cnt_d = train_cnt_q - 8'd1;
                end
            end
            S_HDR: begin
                lane_data_d = HDR_WORD;
                state_d     = S_LEN;
            end
            S_LEN: begin
                lane_data_d = len_q;
                lane_ctl_d  = 1'b0;
                sum_d       = len_q;
                rem_d       = len_q;
                state_d     = (len_q == 8'd0) ? S_CSUM : S_PAY;
            end
            S_PAY: begin
                if (tx_valid) begin
                    lane_data_d = tx_data;
                    lane_ctl_d  = 1'b0;
                    sum_d       = sum_q + tx_data;
                    rem_d       = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                lane_data_d = sum_q;
                lane_ctl_d  = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            train_cnt_q  <= 8'd0;
            len_q        <= 8'd0;
            rem_q        <= 8'd0;
            sum_q        <= 8'd0;
            lane_data_q  <= IDLE_WORD;
            lane_ctl_q   <= 1'b1;
            busy_q       <= 1'b0;
            train_last_q <= 1'b0;
            train_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            train_cnt_q  <= train_cnt_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            sum_q        <= sum_d;
            lane_data_q  <= lane_data_d;
            lane_ctl_q   <= lane_ctl_d;
            busy_q       <= busy_d;
            train_last_q <= train_last_d;
            train_done_q <= train_done_d;
        end
    end

endmodule

// File: tb/tb_frl_tx_lane_framer.sv
// Directed bench for frl_tx_lane_framer: idle, training burst, frames,
// fill words, checksum wrap, request collision and async reset.
module tb_frl_tx_lane_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       train_req;
    logic       frame_start;
    logic [7:0] frame_len;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] lane_data;
    logic       lane_ctl;
    logic       busy;
    logic       train_done;

    int n_assert = 0;
    int n_fail   = 0;
    logic [8:0] exp_q [$];

    frl_tx_lane_framer dut (
        .clk         (clk),
        .rst         (rst),
        .train_req   (train_req),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .lane_data   (lane_data),
        .lane_ctl    (lane_ctl),
        .busy        (busy),
        .train_done  (train_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Lane words are {ctl, data}; expected sequence is in exp_q.
    task automatic run_frame(input logic [7:0] len, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input int gaps, input int rdy_exp,
                             input string nm);
        int idx;
        int g;
        int rdy;
        int n;
        logic [7:0] b [3];
        b   = '{b0, b1, b2};
        idx = 0;
        g   = gaps;
        rdy = 0;
        n   = exp_q.size();
        @(negedge clk);
        frame_start = 1'b1;
        frame_len   = len;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            frame_len   = 8'hEE;
            chk($sformatf("%s lane[%0d]", nm, i),
                {23'd0, lane_ctl, lane_data}, {23'd0, exp_q[i]});
            if (i == n - 2) chk({nm, " busy_last"}, {31'd0, busy}, 32'd1);
            if (i == n - 1) chk({nm, " busy_end"}, {31'd0, busy}, 32'd0);
            tx_valid = 1'b0;
            if (tx_ready) begin
                rdy++;
                if (idx == 1 && g > 0) begin
                    g--;
                end else if (idx < 3) begin
                    tx_valid = 1'b1;
                    tx_data  = b[idx];
                    idx++;
                end
            end
        end
        tx_valid = 1'b0;
        chk({nm, " ready_cycles"}, rdy, rdy_exp);
    endtask

    task automatic run_train(input logic with_frame, input string nm);
        int n5c;
        int nbusy;
        int ndone;
        @(negedge clk);
        train_req   = 1'b1;
        frame_start = with_frame;
        frame_len   = 8'd3;
        @(negedge clk);
        train_req   = 1'b0;
        frame_start = 1'b0;
        chk({nm, " first_lane"}, {23'd0, lane_ctl, lane_data}, 32'h100);
        chk({nm, " first_busy"}, {31'd0, busy}, 32'd0);
        n5c   = 0;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if ({lane_ctl, lane_data} == 9'h15C) n5c++;
            if (busy) nbusy++;
            if (train_done) ndone++;
        end
        chk({nm, " train_words"}, n5c, 128);
        chk({nm, " busy_cycles"}, nbusy, 128);
        chk({nm, " done_early"}, ndone, 0);
        @(negedge clk);
        chk({nm, " end_lane"}, {23'd0, lane_ctl, lane_data}, 32'h100);
        chk({nm, " train_done"}, {31'd0, train_done}, 32'd1);
        chk({nm, " end_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({nm, " done_pulse"}, {31'd0, train_done}, 32'd0);
        chk({nm, " after_lane"}, {23'd0, lane_ctl, lane_data}, 32'h100);
        chk({nm, " after_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        train_req   = 1'b0;
        frame_start = 1'b0;
        frame_len   = 8'd0;
        tx_data     = 8'd0;
        tx_valid    = 1'b0;
        #1;
        chk("rst lane", {23'd0, lane_ctl, lane_data}, 32'h100);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst ready", {31'd0, tx_ready}, 32'd0);
        chk("rst done", {31'd0, train_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("idle lane[%0d]", i),
                {21'd0, lane_ctl, lane_data, busy, tx_ready},
                {21'd0, 9'h100, 1'b0, 1'b0});
        end

        run_train(1'b0, "train");

        exp_q = '{9'h100, 9'h1F5, 9'h003, 9'h010, 9'h020, 9'h030,
                  9'h063, 9'h100};
        run_frame(8'd3, 8'h10, 8'h20, 8'h30, 0, 3, "f3");

        exp_q = '{9'h100, 9'h1F5, 9'h003, 9'h010, 9'h100, 9'h100,
                  9'h020, 9'h030, 9'h063, 9'h100};
        run_frame(8'd3, 8'h10, 8'h20, 8'h30, 2, 5, "f3gap");

        exp_q = '{9'h100, 9'h1F5, 9'h000, 9'h000, 9'h100};
        run_frame(8'd0, 8'h00, 8'h00, 8'h00, 0, 0, "f0");

        exp_q = '{9'h100, 9'h1F5, 9'h002, 9'h0FF, 9'h0FF, 9'h000,
                  9'h100};
        run_frame(8'd2, 8'hFF, 8'hFF, 8'h00, 0, 2, "f2wrap");

        run_train(1'b1, "collide");

        @(negedge clk);
        frame_start = 1'b1;
        frame_len   = 8'd3;
        tx_valid    = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid ready", {31'd0, tx_ready}, 32'd1);
        chk("mid busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst lane", {23'd0, lane_ctl, lane_data}, 32'h100);
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst ready", {31'd0, tx_ready}, 32'd0);
        chk("arst done", {31'd0, train_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        exp_q = '{9'h100, 9'h1F5, 9'h001, 9'h0AA, 9'h0AB, 9'h100};
        run_frame(8'd1, 8'hAA, 8'h00, 8'h00, 0, 1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frl_tx_lane_framer.md
Name: frl_tx_lane_framer

Overview:
- Transmit-side framer for one Fast Radio Link lane; sits between the TX packet source and the lane serializer.
- Emits a fixed-length training burst so the far-end receiver's up/down alignment counter (0..127) can settle.
- Emits framed packets as: header, length, payload, checksum.
- Between bursts and frames, emits idle control words so the receiver always sees a defined symbol stream.

Parameters:
- TRAIN_LEN, 128: number of training words per burst; legal range 1..255.
- TRAIN_WORD, 8'h5C: training symbol, sent with lane_ctl=1.
- HDR_WORD, 8'hF5: frame header symbol, sent with lane_ctl=1.
- IDLE_WORD, 8'h00: idle/fill symbol, sent with lane_ctl=1.

Ports:
- clk  in  1  lane word clock
- rst  in  1  asynchronous, active-high reset
- train_req  in  1  single-cycle pulse; requests a training burst
- frame_start  in  1  single-cycle pulse; requests a frame of frame_len payload bytes
- frame_len  in  8  payload byte count, sampled when frame_start is accepted
- tx_data  in  8  payload byte
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  framer consumes tx_data this cycle when tx_valid=1
- lane_data  out  8  registered lane word to serializer
- lane_ctl  out  1  registered; 1 = control symbol, 0 = data symbol
- busy  out  1  registered; high in every state except IDLE
- train_done  out  1  registered; one-cycle pulse on the cycle after the last training word is emitted

Behaviour:
- Reset (asynchronous, any time, including mid-frame or mid-burst):
  - state=IDLE; lane_data=IDLE_WORD; lane_ctl=1; busy=0; train_done=0; tx_ready=0.
  - Training counter, length counter and checksum are cleared.
  - A partially sent frame is abandoned; nothing is resumed after reset.
- States: IDLE, TRAIN, HDR, LEN, PAY, CSUM.
  - Each state drives its word onto lane_data/lane_ctl at the next clk edge.
  - Lane latency is 1 cycle from state to lane output.
- IDLE:
  - Emits IDLE_WORD/ctl=1.
  - train_req=1 -> TRAIN; training counter loads TRAIN_LEN-1.
  - Otherwise frame_start=1 -> HDR; frame_len is latched.
  - If train_req and frame_start are both high in the same cycle, training wins and the frame request is dropped.
- TRAIN:
  - Emits TRAIN_WORD/ctl=1 and decrements the counter each cycle.
  - When the counter reaches 0 and the word is issued -> IDLE.
  - train_done pulses for exactly one cycle, aligned with the first IDLE word after the burst.
  - Exactly TRAIN_LEN consecutive TRAIN_WORD symbols are emitted.
- HDR:
  - Emits HDR_WORD/ctl=1 for one cycle -> LEN.
- LEN:
  - Emits the latched length/ctl=0.
  - Checksum is initialised to the length value.
  - -> PAY if length != 0; otherwise -> CSUM.
- PAY:
  - tx_ready=1 (combinational decode of state==PAY; 0 in all other states).
  - If tx_valid=1: emit tx_data/ctl=0, add it to the checksum (mod 256), decrement the remaining count.
  - After the last byte is accepted -> CSUM.
  - If tx_valid=0: emit IDLE_WORD/ctl=1 as fill and stay in PAY. Fill words do not count toward length or checksum.
- CSUM:
  - Emits the 8-bit checksum/ctl=0, where checksum = (len + sum of payload bytes) mod 256.
  - -> IDLE.
- busy is registered high starting the cycle after a request is accepted. It returns low on the cycle the first post-frame or post-burst IDLE word appears.
- Requests while busy:
  - train_req and frame_start are ignored when not in IDLE; no queuing.
  - frame_len changes after acceptance have no effect.
- Arithmetic:
  - Checksum and counters are 8-bit and wrap modulo 256.
  - frame_len=255 yields 255 payload bytes.
- Back-to-back operation:
  - A new request may be accepted on the first IDLE cycle after CSUM or TRAIN.
  - Minimum gap on the lane is therefore one IDLE word.

Test Plan:
1. Reset released, no requests -> lane_data=8'h00, lane_ctl=1, busy=0, tx_ready=0 on every cycle.
2. train_req pulse with TRAIN_LEN=128 -> exactly 128 consecutive 8'h5C words with ctl=1, then 8'h00; train_done high for 1 cycle aligned with the first 8'h00; busy high for exactly 128 cycles.
3. frame_start with frame_len=3, tx_valid held high, data 8'h10, 8'h20, 8'h30 -> lane sequence F5(c1), 03(c0), 10, 20, 30(c0), 63(c0), then 00(c1); tx_ready high for exactly 3 cycles.
4. Same frame with tx_valid low for 2 cycles between 8'h10 and 8'h20 -> two 00(c1) fill words inserted after 10; checksum still 8'h63.
5. frame_len=0 -> F5, 00, 00(c0 checksum), then idle; tx_ready never asserts. frame_len=2 with data FF, FF -> checksum (2+FF+FF) mod 256 = 8'h00.
6. train_req and frame_start in the same cycle -> only the training burst is sent. Then assert rst asynchronously mid-PAY -> outputs return to their reset values immediately; a subsequent frame_start produces a clean F5 header.
